// File: rtl/ild_spikes_decoder.sv
// Rate decoder for the P/N spike pair from ild_estimator: counts net spike
// events over a fixed window and presents a saturated signed ILD once per window.
module ild_spikes_decoder #(
    parameter int COUNTER_BITS  = 16,
    parameter int WINDOW_CYCLES = 1024,
    parameter int WINDOW_BITS   = 10
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    SPIKES_IN_P,
    input  logic                    SPIKES_IN_N,
    output logic [COUNTER_BITS-1:0] ILD_OUT,
    output logic                    ILD_VALID,
    output logic                    ILD_SAT
);

    typedef enum logic {
        ACCUM,
        DUMP
    } state_t;

    localparam logic [WINDOW_BITS-1:0]  WIN_LAST = WINDOW_BITS'(WINDOW_CYCLES - 1);
    localparam logic [COUNTER_BITS-1:0] ACC_MAX  = {1'b0, {(COUNTER_BITS-1){1'b1}}};
    localparam logic [COUNTER_BITS-1:0] ACC_MIN  = {1'b1, {(COUNTER_BITS-1){1'b0}}};

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_p_s1;
    logic                    r_p_s2;
    logic                    r_n_s1;
    logic                    r_n_s2;
    logic [COUNTER_BITS-1:0] r_acc;
    logic                    r_sat;
    logic [WINDOW_BITS-1:0]  r_win;
    logic [COUNTER_BITS-1:0] r_ild;
    logic                    r_ild_sat;

    logic                    w_p_evt;
    logic                    w_n_evt;
    logic                    w_inc;
    logic                    w_dec;
    logic                    w_close;
    logic [COUNTER_BITS:0]   w_sum;
    logic                    w_ovf;
    logic [COUNTER_BITS-1:0] w_acc_next;

    assign w_p_evt = r_p_s1 & ~r_p_s2;
    assign w_n_evt = r_n_s1 & ~r_n_s2;
    assign w_inc   = w_p_evt & ~w_n_evt;
    assign w_dec   = w_n_evt & ~w_p_evt;
    assign w_close = (r_win == WIN_LAST);

    // One guard bit: overflow shows up as the two top bits disagreeing.
    always_comb begin
        w_sum = {r_acc[COUNTER_BITS-1], r_acc};
        if (w_inc) begin
            w_sum = w_sum + (COUNTER_BITS+1)'(1);
        end else if (w_dec) begin
            w_sum = w_sum - (COUNTER_BITS+1)'(1);
        end
        w_ovf      = w_sum[COUNTER_BITS] ^ w_sum[COUNTER_BITS-1];
        w_acc_next = w_sum[COUNTER_BITS-1:0];
        if (w_ovf) begin
            w_acc_next = w_sum[COUNTER_BITS] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ILD_VALID    = 1'b0;
        case (r_state)
            ACCUM: begin
                if (w_close) begin
                    w_state_next = DUMP;
                end
            end
            DUMP: begin
                ILD_VALID    = 1'b1;
                w_state_next = ACCUM;
            end
            default: w_state_next = ACCUM;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ACCUM;
            r_p_s1    <= 1'b0;
            r_p_s2    <= 1'b0;
            r_n_s1    <= 1'b0;
            r_n_s2    <= 1'b0;
            r_acc     <= '0;
            r_sat     <= 1'b0;
            r_win     <= '0;
            r_ild     <= '0;
            r_ild_sat <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_p_s1  <= SPIKES_IN_P;
            r_p_s2  <= r_p_s1;
            r_n_s1  <= SPIKES_IN_N;
            r_n_s2  <= r_n_s1;
            r_win   <= w_close ? '0 : r_win + WINDOW_BITS'(1);
            // The final cycle's event belongs to the closing window.
            if (w_close) begin
                r_ild     <= w_acc_next;
                r_ild_sat <= r_sat | w_ovf;
                r_acc     <= '0;
                r_sat     <= 1'b0;
            end else begin
                r_acc <= w_acc_next;
                r_sat <= r_sat | w_ovf;
            end
        end
    end

    assign ILD_OUT = r_ild;
    assign ILD_SAT = r_ild_sat;

endmodule

// File: tb/tb_ild_spikes_decoder.sv
// Scoreboard bench for ild_spikes_decoder: an edge-counting reference model
// pushes expected window results, a negedge monitor pops and compares.
module tb_ild_spikes_decoder;

    localparam int CB   = 4;
    localparam int W    = 16;
    localparam int WB   = 4;
    localparam int AMAX = 7;
    localparam int AMIN = -8;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          p_in  = 1'b0;
    logic          n_in  = 1'b0;
    logic [CB-1:0] ild_out;
    logic          ild_valid;
    logic          ild_sat;

    ild_spikes_decoder #(
        .COUNTER_BITS (CB),
        .WINDOW_CYCLES(W),
        .WINDOW_BITS  (WB)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .SPIKES_IN_P(p_in),
        .SPIKES_IN_N(n_in),
        .ILD_OUT    (ild_out),
        .ILD_VALID  (ild_valid),
        .ILD_SAT    (ild_sat)
    );

    always #20 clk = ~clk;

    typedef struct {
        int value;
        bit sat;
    } win_t;

    win_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state: clamped integer sum of rising edges seen on the inputs.
    int   m_acc      = 0;
    int   m_pend     = 0;
    int   m_edges    = 0;
    int   m_held     = 0;
    bit   m_sat      = 1'b0;
    bit   m_held_sat = 1'b0;
    bit   m_prev_p   = 1'b0;
    bit   m_prev_n   = 1'b0;

    function automatic void chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endfunction

    function automatic void chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endfunction

    // A rising input seen at one edge is counted at the following edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_acc      = 0;
                m_pend     = 0;
                m_edges    = 0;
                m_sat      = 1'b0;
                m_held     = 0;
                m_held_sat = 1'b0;
                m_prev_p   = 1'b0;
                m_prev_n   = 1'b0;
            end else begin
                m_acc = m_acc + m_pend;
                if (m_acc > AMAX) begin
                    m_acc = AMAX;
                    m_sat = 1'b1;
                end else if (m_acc < AMIN) begin
                    m_acc = AMIN;
                    m_sat = 1'b1;
                end
                m_edges++;
                if (m_edges % W == 0) begin
                    sb_q.push_back('{m_acc, m_sat});
                    m_held     = m_acc;
                    m_held_sat = m_sat;
                    m_acc      = 0;
                    m_sat      = 1'b0;
                end
                m_pend   = int'(p_in && !m_prev_p) - int'(n_in && !m_prev_n);
                m_prev_p = p_in;
                m_prev_n = n_in;
            end
        end
    end

    initial begin
        win_t e;
        forever begin
            @(negedge clk);
            chk_bit("valid", ild_valid, sb_q.size() != 0);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                if (ild_valid) begin
                    chk_int("strobe_out", $signed(ild_out), e.value);
                    chk_bit("strobe_sat", ild_sat, e.sat);
                end
            end
            chk_int("hold_out", $signed(ild_out), m_held);
            chk_bit("hold_sat", ild_sat, m_held_sat);
        end
    end

    task automatic cyc(input logic p, input logic n);
        p_in = p;
        n_in = n;
        @(negedge clk);
    endtask

    task automatic idle(input int c);
        repeat (c) cyc(1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic hold_p);
        rst = 1'b1;
        cyc(hold_p, 1'b0);
        cyc(hold_p, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        int mode;
        int len;
        int rst_at;

        rst  = 1'b1;
        p_in = 1'b0;
        n_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Mixed: 3 P and 1 N pulses, then an empty window.
        cyc(0, 0); cyc(1, 0); cyc(0, 0); cyc(1, 0);
        cyc(0, 0); cyc(1, 0); cyc(0, 0); cyc(0, 1);
        idle(2 * W - 8);

        // 12 N pulses, then empty windows.
        repeat (12) begin cyc(0, 1); cyc(0, 0); end
        idle(2 * W);

        // Window-aligned positive saturation and exact negative limit.
        do_reset(1'b0);
        repeat (8) begin cyc(1, 0); cyc(0, 0); end
        idle(W);
        do_reset(1'b0);
        repeat (8) begin cyc(0, 1); cyc(0, 0); end
        idle(W);

        // Simultaneous P/N, then one wide P pulse.
        do_reset(1'b0);
        repeat (3) begin cyc(1, 1); cyc(0, 0); end
        idle(W);
        repeat (5) cyc(1, 0);
        idle(2 * W);

        // Window boundary: last-cycle event and one-cycle-later event.
        do_reset(1'b0);
        idle(14);
        cyc(1, 0);
        idle(16);
        cyc(1, 0);
        idle(2 * W);

        // Reset mid-window after a nonzero result is being held.
        do_reset(1'b0);
        repeat (3) begin cyc(1, 0); cyc(0, 0); end
        idle(W - 6);
        repeat (4) begin cyc(1, 0); cyc(0, 0); end
        idle(2);
        do_reset(1'b0);
        repeat (2) begin cyc(1, 0); cyc(0, 0); end
        idle(2 * W);

        // Level held through reset counts once.
        do_reset(1'b1);
        repeat (3) cyc(1, 0);
        idle(2 * W);

        // Randomized bursts with occasional resets.
        for (int b = 0; b < 40; b++) begin
            mode   = $urandom_range(0, 3);
            len    = $urandom_range(8, 3 * W);
            rst_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, len - 1) : -1;
            for (int c = 0; c < len; c++) begin
                if (c == rst_at) do_reset(1'($urandom_range(0, 1)));
                case (mode)
                    0: cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    1: cyc((c % 2 == 0) && ($urandom_range(0, 7) != 0), 1'b0);
                    2: cyc(1'b0, (c % 2 == 0) && ($urandom_range(0, 7) != 0));
                    default: cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
                endcase
            end
        end

        idle(W + 2);
        chk_int("queue_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
